sample_ring_writer: RTL and testbench

Streaming front end for the DSP data memory (`datamem`). It takes input samples over a valid/ready handshake and writes them into a circular region of data memory. On request, it reads back the N most recent samples, newest first, as a tap stream for the downstream filter datapath. It is the only master on the `datamem` port.

---
 rtl/dsp_pkg.sv | 14 +
 rtl/ring_ptr.sv | 30 +++
 rtl/sample_ring_writer.sv | 156 +++++++++++++++
 tb/tb_sample_ring_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP data-memory front end.
package dsp_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ring_ptr.sv
// Modulo-LEN pointer: load has priority over inc, inc over dec.
module ring_ptr #(
  parameter int unsigned W   = 8,
  parameter int unsigned LEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  // Pointer register with wrap in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end else if (dec) begin
      ptr <= (ptr == '0) ? LAST : ptr - W'(1);
    end
  end

endmodule

// File: rtl/sample_ring_writer.sv
// Streams input samples into a circular region of datamem and reads the
// newest N back, newest first, as a back-to-back tap stream.
module sample_ring_writer #(
  parameter int unsigned       ADDR_W = dsp_pkg::ADDR_W,
  parameter int unsigned       DATA_W = dsp_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE   = 8'h10,
  parameter int unsigned       LEN    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              tap_start,
  input  logic [ADDR_W:0]   tap_count,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic              tap_last,
  output logic              tap_busy,
  output logic              tap_err,
  output logic [ADDR_W:0]   fill,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  import dsp_pkg::*;

  localparam logic [ADDR_W:0]   LEN_C    = (ADDR_W + 1)'(LEN);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(LEN - 1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   wptr_back;
  logic [ADDR_W-1:0]   rptr;
  logic [ADDR_W-1:0]   rptr_init;
  logic [ADDR_W:0]     fill_q;
  logic [ADDR_W:0]     fill_next;
  logic [ADDR_W:0]     cnt;
  logic                in_idle;
  logic                in_read;
  logic                wr_fire;
  logic                req;
  logic                req_ok;
  logic                tap_go;
  logic                tap_reject;
  logic                last_issue;
  logic                tap_valid_q;
  logic                tap_last_q;
  logic                tap_err_q;

  assign in_idle = (state == ST_IDLE);
  assign in_read = (state == ST_READ);

  // Handshake is masked while reset is held so nothing is written then.
  assign s_ready = rst_n & in_idle;
  assign wr_fire = s_ready & s_valid;

  assign mem_en   = wr_fire;
  assign mem_din  = s_data;
  assign mem_addr = in_read ? (BASE + rptr) : (BASE + wptr);

  // Fill as it will be after a write in this cycle; readout checks use it.
  assign fill_next = (wr_fire && (fill_q != LEN_C)) ? fill_q + CNT_ONE : fill_q;

  assign req        = rst_n & in_idle & tap_start;
  assign req_ok     = (tap_count != '0) && (tap_count <= fill_next);
  assign tap_go     = req & req_ok;
  assign tap_reject = req & ~req_ok;

  // Newest sample sits one behind the post-write pointer; when a write
  // lands in the same cycle that is simply the current wptr.
  assign wptr_back = (wptr == '0) ? PTR_LAST : wptr - ADDR_W'(1);
  assign rptr_init = wr_fire ? wptr : wptr_back;

  assign last_issue = in_read && (cnt == CNT_ONE);

  ring_ptr #(
    .W   (ADDR_W),
    .LEN (LEN)
  ) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (wr_fire),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wptr)
  );

  ring_ptr #(
    .W   (ADDR_W),
    .LEN (LEN)
  ) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (1'b0),
    .dec      (in_read),
    .load     (tap_go),
    .load_val (rptr_init),
    .ptr      (rptr)
  );

  // Next-state selection for the readout sequencer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (tap_go) state_next = ST_READ;
      ST_READ:  if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, remaining-tap count and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      fill_q <= '0;
    end else begin
      state  <= state_next;
      fill_q <= fill_next;
      if (tap_go) begin
        cnt <= tap_count;
      end else if (in_read) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Return-path pipeline: flags follow the address by one cycle to line up
  // with datamem read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_err_q   <= 1'b0;
    end else begin
      tap_valid_q <= in_read;
      tap_last_q  <= last_issue;
      tap_err_q   <= tap_reject;
    end
  end

  assign tap_valid = tap_valid_q;
  assign tap_last  = tap_last_q;
  assign tap_err   = tap_err_q;
  assign tap_data  = tap_valid_q ? mem_dout : '0;
  assign tap_busy  = ~in_idle;
  assign fill      = fill_q;

endmodule

// File: tb/tb_sample_ring_writer.sv
// Directed bench for sample_ring_writer with a datamem model and tap scoreboard.
module tb_sample_ring_writer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN    = 32;
  localparam logic [7:0]  BASE   = 8'h10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              tap_start;
  logic [ADDR_W:0]   tap_count;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic              tap_last;
  logic              tap_busy;
  logic              tap_err;
  logic [ADDR_W:0]   fill;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } tap_t;

  tap_t              exp_q[$];
  logic [DATA_W-1:0] hist[$];
  logic [7:0]        addr_q[$];
  logic [DATA_W-1:0] mem [0:255];
  int                checks   = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  sample_ring_writer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BASE   (BASE),
    .LEN    (LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .tap_start (tap_start),
    .tap_count (tap_count),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .tap_last  (tap_last),
    .tap_busy  (tap_busy),
    .tap_err   (tap_err),
    .fill      (fill),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Synchronous datamem model: write and registered read on the same edge.
  always @(posedge clk) begin
    if (mem_en) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fill();
    return (hist.size() > LEN) ? LEN : hist.size();
  endfunction

  function automatic logic [31:0] next_waddr();
    return 32'(BASE) + 32'(hist.size() % LEN);
  endfunction

  // Tap scoreboard: every valid tap must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && tap_valid) begin
      tap_t e;
      check("tap_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tap_data", 32'(tap_data), 32'(e.data));
        check("tap_last_sb", 32'(tap_last), 32'(e.last));
      end
    end
  end

  task automatic push_taps(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: hist[hist.size() - 1 - i], last: (i == n - 1)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_tap_valid", 32'(tap_valid), 32'd0);
    check("rst_tap_busy", 32'(tap_busy), 32'd0);
    check("rst_tap_err", 32'(tap_err), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    hist.delete();
    exp_q.delete();
  endtask

  task automatic write(input logic [DATA_W-1:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    #1;
    check("wr_en", 32'(mem_en), 32'd1);
    check("wr_addr", 32'(mem_addr), next_waddr());
    hist.push_back(d);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Full readout with optional same-cycle write; checks timing cycle by cycle.
  task automatic readout(input int n, input bit wr, input logic [DATA_W-1:0] d);
    @(negedge clk);
    tap_start = 1'b1;
    tap_count = (ADDR_W + 1)'(n);
    if (wr) begin
      s_valid = 1'b1;
      s_data = d;
      #1;
      check("rdwr_en", 32'(mem_en), 32'd1);
      check("rdwr_addr", 32'(mem_addr), next_waddr());
      hist.push_back(d);
    end
    push_taps(n);
    @(posedge clk);
    #1;
    tap_start = 1'b0;
    s_valid = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k <= n && addr_q.size() != 0) check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      check("rd_busy", 32'(tap_busy), 32'(k <= n + 1));
      check("rd_s_ready", 32'(s_ready), 32'(k == n + 2));
      check("rd_valid", 32'(tap_valid), 32'(k >= 2 && k <= n + 1));
      check("rd_last", 32'(tap_last), 32'(k == n + 1));
    end
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reject(input int n);
    @(negedge clk);
    tap_start = 1'b1;
    tap_count = (ADDR_W + 1)'(n);
    #1;
    check("rej_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 tap_start = 1'b0;
    @(negedge clk);
    check("rej_err", 32'(tap_err), 32'd1);
    check("rej_busy", 32'(tap_busy), 32'd0);
    check("rej_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    check("rej_err_drop", 32'(tap_err), 32'd0);
    check("rej_valid", 32'(tap_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    tap_start = 1'b0;
    tap_count = '0;

    // Three writes then a 3-tap readout.
    do_reset();
    write(16'h0001);
    write(16'h0002);
    write(16'h0003);
    @(negedge clk);
    check("fill3", 32'(fill), 32'(model_fill()));
    addr_q = '{8'h12, 8'h11, 8'h10};
    readout(3, 1'b0, '0);

    // Wraparound: 34 writes, readout crosses the ring boundary.
    do_reset();
    for (int v = 1; v <= 34; v++) write(16'(v));
    @(negedge clk);
    check("fill_sat", 32'(fill), 32'(model_fill()));
    check("mem_0x10", 32'(mem[8'h10]), 32'd33);
    addr_q = '{8'h11, 8'h10, 8'h2F, 8'h2E};
    readout(4, 1'b0, '0);

    // Rejected requests: too many and zero taps.
    do_reset();
    write(16'h0011);
    write(16'h0022);
    write(16'h0033);
    reject(5);
    reject(0);
    check("fill_after_rej", 32'(fill), 32'(model_fill()));

    // Same-cycle write and single-tap request.
    addr_q = '{8'h13};
    readout(1, 1'b1, 16'h00AA);
    check("fill_after_rdwr", 32'(fill), 32'(model_fill()));

    // Reset during a 10-tap readout; start requests while busy are ignored.
    do_reset();
    for (int v = 0; v < 10; v++) write(16'h0100 + 16'(v));
    @(negedge clk);
    tap_start = 1'b1;
    tap_count = 9'd10;
    push_taps(10);
    @(posedge clk);
    #1 tap_start = 1'b0;
    @(negedge clk);
    tap_start = 1'b1;
    tap_count = 9'd1;
    @(posedge clk);
    #1 tap_start = 1'b0;
    @(negedge clk);
    check("busy_start_err", 32'(tap_err), 32'd0);
    check("busy_mid", 32'(tap_busy), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tap_valid), 32'd0);
    check("mid_rst_busy", 32'(tap_busy), 32'd0);
    check("mid_rst_last", 32'(tap_last), 32'd0);
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    hist.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    write(16'h0BEE);
    addr_q = '{8'h10};
    readout(1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
